// File: rtl/in_debouncer.sv
// Input conditioner: synchronizes an asynchronous raw level, rejects short glitches,
// and emits a clean registered level with single-cycle rise/fall pulses.
module in_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic async_rst,
    input  logic raw_in,
    input  logic enable,
    output logic in_clean,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_q;
    state_t                 r_state,    w_state_nxt;
    logic [CNT_W-1:0]       r_cnt,      w_cnt_nxt;
    logic                   r_in_clean, w_in_clean_nxt;
    logic                   r_rise,     w_rise_nxt;
    logic                   r_fall,     w_fall_nxt;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // The synchronizer runs regardless of enable so sync_q is always current.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_state    <= STABLE_LOW;
            r_cnt      <= '0;
            r_in_clean <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_clean <= w_in_clean_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_in_clean_nxt = r_in_clean;
        w_rise_nxt     = 1'b0;
        w_fall_nxt     = 1'b0;

        case (r_state)
            STABLE_LOW: begin
                if (w_sync_q && enable) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt    = STABLE_HIGH;
                        w_in_clean_nxt = 1'b1;
                        w_rise_nxt     = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!w_sync_q || !enable) begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = STABLE_HIGH;
                    w_cnt_nxt      = '0;
                    w_in_clean_nxt = 1'b1;
                    w_rise_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!w_sync_q && enable) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt    = STABLE_LOW;
                        w_in_clean_nxt = 1'b0;
                        w_fall_nxt     = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            WAIT_LOW: begin
                if (w_sync_q || !enable) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = STABLE_LOW;
                    w_cnt_nxt      = '0;
                    w_in_clean_nxt = 1'b0;
                    w_fall_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt    = STABLE_LOW;
                w_cnt_nxt      = '0;
                w_in_clean_nxt = 1'b0;
            end
        endcase
    end

    assign in_clean   = r_in_clean;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: tb/tb_in_debouncer.sv
// Directed bench for in_debouncer: default instance plus a DEBOUNCE_CYCLES=1,
// SYNC_STAGES=3 instance; expected values are hand-derived edge by edge.
module tb_in_debouncer;

    logic clk = 1'b0;
    logic async_rst;
    logic raw_a, en_a, clean_a, rise_a, fall_a;
    logic raw_b, en_b, clean_b, rise_b, fall_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    in_debouncer dut_a (
        .clk        (clk),
        .async_rst  (async_rst),
        .raw_in     (raw_a),
        .enable     (en_a),
        .in_clean   (clean_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a)
    );

    in_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk        (clk),
        .async_rst  (async_rst),
        .raw_in     (raw_b),
        .enable     (en_b),
        .in_clean   (clean_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic e_clean, input logic e_rise,
                           input logic e_fall);
        check({tag, ".in_clean"},   clean_a, e_clean);
        check({tag, ".rise_pulse"}, rise_a,  e_rise);
        check({tag, ".fall_pulse"}, fall_a,  e_fall);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        async_rst = 1'b0;
        raw_a = 1'b0; en_a = 1'b1;
        raw_b = 1'b0; en_b = 1'b1;

        // Reset state
        repeat (3) tick();
        check_a("reset", 1'b0, 1'b0, 1'b0);
        check("reset_b.in_clean", clean_b, 1'b0);
        async_rst = 1'b1;
        repeat (2) tick();

        // DEBOUNCE_CYCLES=1, SYNC_STAGES=3: one-sample pulse captured at E0.
        // sync_q high after E2 only; accepted at E3, released at E4.
        raw_b = 1'b1;
        tick();
        raw_b = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            check($sformatf("short_b.e%0d.in_clean", i), clean_b, i == 3);
            check($sformatf("short_b.e%0d.rise", i),     rise_b,  i == 3);
            check($sformatf("short_b.e%0d.fall", i),     fall_b,  i == 4);
            tick();
        end

        // Defaults: held high is accepted after E5 counted from capture edge E0.
        raw_a = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            check_a($sformatf("rise.e%0d", i), i >= 5, i == 5, 1'b0);
        end

        // Held low from accepted high: falls after E5, fall pulse one cycle.
        raw_a = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            tick();
            check_a($sformatf("fall.e%0d", i), i < 5, 1'b0, i == 5);
        end
        repeat (3) tick();

        // Glitch of 3 cycles is rejected.
        raw_a = 1'b1;
        repeat (3) tick();
        raw_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_a($sformatf("glitch3.c%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // High 3 / low 1 / high 3: the count restarts, so never accepted.
        raw_a = 1'b1;
        repeat (3) tick();
        raw_a = 1'b0;
        tick();
        raw_a = 1'b1;
        repeat (3) tick();
        raw_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_a($sformatf("restart.c%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Disabled with raw high for 20 cycles: level frozen low.
        en_a  = 1'b0;
        raw_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_a($sformatf("frozen_lo.c%0d", i), 1'b0, 1'b0, 1'b0);
        end
        // Re-enable: four enabled edges F1..F4 are needed.
        en_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_a($sformatf("reenable_hi.f%0d", i), i >= 4, i == 4, 1'b0);
        end

        // Disabled while accepted high and raw low: level frozen high.
        en_a  = 1'b0;
        raw_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_a($sformatf("frozen_hi.c%0d", i), 1'b1, 1'b0, 1'b0);
        end
        en_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_a($sformatf("reenable_lo.f%0d", i), i < 4, 1'b0, i == 4);
        end
        repeat (2) tick();

        // Async reset mid-WAIT_HIGH, between edges.
        raw_a = 1'b1;
        repeat (4) tick();
        check_a("pre_rst_wait", 1'b0, 1'b0, 1'b0);
        #3 async_rst = 1'b0;
        #1 check_a("rst_in_wait", 1'b0, 1'b0, 1'b0);
        #1 async_rst = 1'b1;
        // Sync chain was cleared; raw still high, so the next edge is E0 again.
        for (int i = 0; i <= 6; i++) begin
            tick();
            check_a($sformatf("post_rst.e%0d", i), i >= 5, i == 5, 1'b0);
        end

        // Async reset during a rise-pulse cycle forces all outputs low at once.
        async_rst = 1'b0;
        #1 async_rst = 1'b1;
        repeat (5) tick();
        check_a("pulse_cycle", 1'b0, 1'b0, 1'b0);
        tick();
        check_a("pulse_cycle_hi", 1'b1, 1'b1, 1'b0);
        #3 async_rst = 1'b0;
        #1 check_a("rst_in_pulse", 1'b0, 1'b0, 1'b0);
        raw_a = 1'b0;
        #1 async_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_a($sformatf("rst_exit.c%0d", i), 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
